unified_mem_arbiter: RTL

Shares one single-ported, fixed-latency memory between the pipelined MIPS core's instruction-fetch port and its MEM-stage data port. It serialises requests, one transaction outstanding at a time. It returns per-port acknowledge and read data, and drives the stall signals that freeze the IF and MEM stages while a port waits.

---
 rtl/mips_mem_pkg.sv | 22 ++
 rtl/mem_lat_counter.sv | 33 +++
 rtl/unified_mem_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mips_mem_pkg;

    // Arbiter sequencing: sample requests, strobe memory, wait out latency, pulse ack.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StAck   = 2'd3
    } arb_state_e;

    // Which port owns the transaction in flight.
    typedef enum logic {
        OwnerFetch = 1'b0,
        OwnerData  = 1'b1
    } owner_e;

    localparam int unsigned MemLatDefault = 2;
    localparam int unsigned MemLatMax     = 15;
    localparam int unsigned CntW          = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times the memory read latency; tc_o flags zero.
module mem_lat_counter
    import mips_mem_pkg::*;
#(
    parameter int unsigned Width = CntW
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q;

    // Load has priority; decrement saturates at zero so the count never wraps.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Terminal count: the cycle in which the memory's read data is valid.
    always_comb begin
        tc_o = (cnt_q == '0);
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises the fetch and data ports onto one fixed-latency memory port,
// one transaction at a time, with alternating priority under contention.
module unified_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = MemLatDefault
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_if_o,
    output logic              stall_mem_o,
    output logic              busy_o
);

    localparam logic [CntW-1:0] LatLoad = CntW'(MEM_LAT - 1);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_grant_q, last_grant_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;
    logic              grant_data;
    logic              cnt_load, cnt_dec, cnt_tc;

    mem_lat_counter #(
        .Width (CntW)
    ) u_lat_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (cnt_load),
        .load_val_i (LatLoad),
        .dec_i      (cnt_dec),
        .tc_o       (cnt_tc)
    );

    // Next-state: arbitration in idle, memory strobe, latency wait, ack pulse.
    // The mem_* registers double as the grant-time latches; they read as zero
    // except during the single issue cycle.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        grant_data   = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (if_req_i || d_req_i) begin
                    // Data wins ties unless it also won the previous grant.
                    grant_data   = d_req_i && !(if_req_i && (last_grant_q == OwnerData));
                    owner_d      = grant_data ? OwnerData : OwnerFetch;
                    last_grant_d = owner_d;
                    mem_req_d    = 1'b1;
                    mem_we_d     = grant_data && d_we_i;
                    mem_addr_d   = grant_data ? d_addr_i : if_addr_i;
                    mem_wdata_d  = grant_data ? d_wdata_i : '0;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (mem_we_q) begin
                    d_ack_d = 1'b1;
                    state_d = StAck;
                end else begin
                    // With MEM_LAT == 1 the count loads as zero, so the wait
                    // state captures on its first cycle.
                    cnt_load = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (cnt_tc) begin
                    if (owner_q == OwnerData) begin
                        d_rdata_d = mem_rdata_i;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata_i;
                        if_ack_d   = 1'b1;
                    end
                    state_d = StAck;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            owner_q      <= OwnerFetch;
            last_grant_q <= OwnerFetch;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    // Output drive; stalls are combinational so they drop in the ack cycle.
    always_comb begin
        mem_req_o   = mem_req_q;
        mem_we_o    = mem_we_q;
        mem_addr_o  = mem_addr_q;
        mem_wdata_o = mem_wdata_q;
        if_ack_o    = if_ack_q;
        d_ack_o     = d_ack_q;
        if_rdata_o  = if_rdata_q;
        d_rdata_o   = d_rdata_q;
        busy_o      = busy_q;
        stall_if_o  = if_req_i & ~if_ack_q;
        stall_mem_o = d_req_i & ~d_ack_q;
    end

endmodule
